// File: rtl/rv32i_datapath.sv
// rv32i_datapath: single-cycle RV32I datapath driven by an external decoder
module rv32i_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        isALUreg,
  input  logic        regWrite,
  input  logic        isJAL,
  input  logic        isJALR,
  input  logic        isBranch,
  input  logic        isLUI,
  input  logic        isAUIPC,
  input  logic        isLoad,
  input  logic        isStore,
  input  logic        isShamt,
  input  logic [2:0]  funct3,
  input  logic [3:0]  aluControl,
  input  logic [31:0] instr,
  input  logic [31:0] memRdata,
  output logic [31:0] pc,
  output logic [31:0] aluOut,
  output logic [31:0] memWdata,
  output logic [3:0]  memWMask,
  output logic        isZero
);
  logic [31:0] rf [32];
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] r1, r2, imm_i, imm_s, imm_b, imm_u, imm_j, b, pc4, npc, wb, ld;
  logic [7:0]  by;
  logic [15:0] hw;
  logic [4:0]  sh;
  logic        taken;
  logic        unused;
  assign unused = ^instr[6:0];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];
  assign rd  = instr[11:7];
  assign r1 = rs1 == 5'd0 ? 32'd0 : rf[rs1];
  assign r2 = rs2 == 5'd0 ? 32'd0 : rf[rs2];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  assign b = isALUreg ? r2 : isShamt ? {27'd0, instr[24:20]} : isStore ? imm_s : imm_i;
  assign sh = b[4:0];
  always_comb begin
    aluOut = 32'd0;
    case (aluControl)
      4'b0000: aluOut = r1 + b;
      4'b0001: aluOut = r1 - b;
      4'b0010: aluOut = r1 << sh;
      4'b0011: aluOut = {31'd0, $signed(r1) < $signed(b)};
      4'b0100: aluOut = {31'd0, r1 < b};
      4'b0101: aluOut = r1 ^ b;
      4'b0110: aluOut = r1 >> sh;
      4'b0111: aluOut = $signed(r1) >>> sh;
      4'b1000: aluOut = r1 | b;
      4'b1001: aluOut = r1 & b;
      default: aluOut = 32'd0;
    endcase
  end
  assign isZero = aluOut == 32'd0;
  // bit 0 of funct3 inverts the base comparison (NE, GE, GEU)
  assign taken = funct3[2] ? ((funct3[1] ? r1 < r2 : $signed(r1) < $signed(r2)) ^ funct3[0])
                           : (!funct3[1] && ((r1 == r2) ^ funct3[0]));
  assign pc4 = pc + 32'd4;
  assign npc = isJAL ? pc + imm_j : isJALR ? (r1 + imm_i) & ~32'd1 : (isBranch && taken) ? pc + imm_b : pc4;
  assign by = memRdata[8*aluOut[1:0] +: 8];
  assign hw = memRdata[16*aluOut[1] +: 16];
  assign ld = funct3[1:0] == 2'b00 ? {{24{~funct3[2] & by[7]}}, by}
            : funct3[1:0] == 2'b01 ? {{16{~funct3[2] & hw[15]}}, hw} : memRdata;
  assign wb = (isJAL || isJALR) ? pc4 : isLUI ? imm_u : isAUIPC ? pc + imm_u : isLoad ? ld : aluOut;
  assign memWdata = funct3[1:0] == 2'b00 ? {4{r2[7:0]}} : funct3[1:0] == 2'b01 ? {2{r2[15:0]}} : r2;
  assign memWMask = !isStore ? 4'b0000 : funct3[1:0] == 2'b00 ? 4'b0001 << aluOut[1:0]
                  : funct3[1:0] == 2'b01 ? (aluOut[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else begin
      pc <= npc;
      if (regWrite && rd != 5'd0) rf[rd] <= wb;
    end
  end
endmodule

// File: tb/tb_rv32i_datapath.sv
// tb_rv32i_datapath: directed vector table plus randomized run against a reference model
module tb_rv32i_datapath;
  logic clk = 0, reset;
  logic isALUreg, regWrite, isJAL, isJALR, isBranch, isLUI, isAUIPC, isLoad, isStore, isShamt;
  logic [2:0] funct3;
  logic [3:0] aluControl, memWMask;
  logic [31:0] instr, memRdata, pc, aluOut, memWdata;
  logic isZero;
  int checks = 0, errors = 0;

  localparam logic [9:0] AR = 10'h200, RW = 10'h100, JL = 10'h080, JR = 10'h040, BR = 10'h020,
                         LU = 10'h010, AU = 10'h008, LD = 10'h004, ST = 10'h002, SA = 10'h001;

  typedef struct {
    logic rst; logic [9:0] fl; logic [2:0] f3; logic [3:0] ac;
    logic [31:0] ins, mrd, pc, alu; logic [3:0] wm; logic [31:0] wd;
  } vec_t;
  vec_t tv[$];

  rv32i_datapath dut (
    .clk(clk), .reset(reset), .isALUreg(isALUreg), .regWrite(regWrite), .isJAL(isJAL),
    .isJALR(isJALR), .isBranch(isBranch), .isLUI(isLUI), .isAUIPC(isAUIPC), .isLoad(isLoad),
    .isStore(isStore), .isShamt(isShamt), .funct3(funct3), .aluControl(aluControl),
    .instr(instr), .memRdata(memRdata), .pc(pc), .aluOut(aluOut), .memWdata(memWdata),
    .memWMask(memWMask), .isZero(isZero)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", n, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [9:0] fl, input logic [2:0] f3, input logic [3:0] ac,
                       input logic [31:0] ins, input logic [31:0] mrd);
    reset = r;
    {isALUreg, regWrite, isJAL, isJALR, isBranch, isLUI, isAUIPC, isLoad, isStore, isShamt} = fl;
    funct3 = f3; aluControl = ac; instr = ins; memRdata = mrd;
  endtask

  function automatic vec_t mk(input logic [31:0] p, input logic [9:0] fl, input logic [2:0] f3,
                              input logic [3:0] ac, input logic [31:0] ins, input logic [31:0] mrd,
                              input logic [31:0] alu, input logic [3:0] wm, input logic [31:0] wd,
                              input logic r);
    vec_t v;
    v.pc = p; v.fl = fl; v.f3 = f3; v.ac = ac; v.ins = ins; v.mrd = mrd;
    v.alu = alu; v.wm = wm; v.wd = wd; v.rst = r;
    return v;
  endfunction

  logic [31:0] m_rf [32];
  logic [31:0] m_pc;

  task automatic rstep(input logic r, input logic [9:0] fl, input logic [2:0] f3, input logic [3:0] ac,
                       input logic [31:0] ins, input logic [31:0] mrd);
    logic [31:0] a, b2, ii, is, ib, iu, ij, ob, e_alu, e_wd, e_wb, e_np, bv, hv, ldv;
    logic [3:0] e_wm;
    logic tk;
    int sh, off;
    a = m_rf[ins[19:15]]; b2 = m_rf[ins[24:20]];
    ii = $signed(ins) >>> 20;
    is = {ii[31:5], ins[11:7]};
    ib = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    iu = ins & 32'hFFFF_F000;
    ij = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    ob = fl[9] ? b2 : fl[0] ? {27'd0, ins[24:20]} : fl[1] ? is : ii;
    sh = ob % 32;
    case (ac)
      0: e_alu = a + ob;
      1: e_alu = a - ob;
      2: e_alu = a << sh;
      3: e_alu = ($signed(a) < $signed(ob)) ? 1 : 0;
      4: e_alu = (a < ob) ? 1 : 0;
      5: e_alu = a ^ ob;
      6: e_alu = a >> sh;
      7: e_alu = $signed(a) >>> sh;
      8: e_alu = a | ob;
      9: e_alu = a & ob;
      default: e_alu = 0;
    endcase
    case (f3)
      0: tk = a == b2;
      1: tk = a != b2;
      4: tk = $signed(a) < $signed(b2);
      5: tk = $signed(a) >= $signed(b2);
      6: tk = a < b2;
      7: tk = a >= b2;
      default: tk = 0;
    endcase
    off = e_alu % 4;
    bv = (mrd >> (8 * off)) & 32'hFF;
    hv = (mrd >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      0: ldv = bv >= 128 ? bv | 32'hFFFF_FF00 : bv;
      1: ldv = hv >= 32768 ? hv | 32'hFFFF_0000 : hv;
      4: ldv = bv;
      5: ldv = hv;
      default: ldv = mrd;
    endcase
    case (f3 % 4)
      0: begin e_wd = (b2 & 32'hFF) * 32'h0101_0101; e_wm = 4'(1 << off); end
      1: begin e_wd = (b2 & 32'hFFFF) * 32'h0001_0001; e_wm = off >= 2 ? 4'hC : 4'h3; end
      default: begin e_wd = b2; e_wm = 4'hF; end
    endcase
    if (!fl[1]) e_wm = 0;
    e_wb = (fl[7] || fl[6]) ? m_pc + 4 : fl[4] ? iu : fl[3] ? m_pc + iu : fl[2] ? ldv : e_alu;
    e_np = fl[7] ? m_pc + ij : fl[6] ? (a + ii) & 32'hFFFF_FFFE : (fl[5] && tk) ? m_pc + ib : m_pc + 4;
    drive(r, fl, f3, ac, ins, mrd);
    #1;
    chk("rnd_pc", pc, m_pc);
    chk("rnd_alu", aluOut, e_alu);
    chk("rnd_zero", {31'd0, isZero}, (e_alu == 0) ? 1 : 0);
    chk("rnd_mask", {28'd0, memWMask}, {28'd0, e_wm});
    if (fl[1]) chk("rnd_wdata", memWdata, e_wd);
    @(posedge clk); #1;
    if (r) begin
      m_pc = 0;
      for (int i = 0; i < 32; i++) m_rf[i] = 0;
    end else begin
      m_pc = e_np;
      if (fl[8] && ins[11:7] != 0) m_rf[ins[11:7]] = e_wb;
    end
  endtask

  initial begin
    logic [9:0] fl;
    logic [2:0] f3;
    logic [3:0] ac;
    logic [31:0] ins;
    int cls;
    logic [2:0] ldf [5];
    ldf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    tv.push_back(mk(0,   RW, 0, 0, 32'h00000013, 0, 0, 0, 0, 0));
    tv.push_back(mk(4,   RW, 0, 0, 32'h00000013, 0, 0, 0, 0, 0));
    tv.push_back(mk(8,   RW, 0, 0, 32'h00000013, 0, 0, 0, 0, 0));
    tv.push_back(mk(12,  RW, 0, 0, 32'h00500093, 0, 5, 0, 0, 0));
    tv.push_back(mk(16,  AR|RW, 0, 0, 32'h00108133, 0, 10, 0, 0, 0));
    tv.push_back(mk(20,  AR|RW, 0, 1, 32'h401081B3, 0, 0, 0, 0, 0));
    tv.push_back(mk(24,  BR|AR, 0, 1, 32'h00108463, 0, 0, 0, 0, 0));
    tv.push_back(mk(32,  BR|AR, 1, 1, 32'h00109463, 0, 0, 0, 0, 0));
    tv.push_back(mk(36,  JL|RW, 0, 0, 32'h010000EF, 0, 16, 0, 0, 0));
    tv.push_back(mk(52,  JR|RW, 0, 0, 32'h00008067, 0, 40, 0, 0, 0));
    tv.push_back(mk(40,  LU|RW, 0, 0, 32'h123452B7, 0, 32'h123, 0, 0, 0));
    tv.push_back(mk(44,  RW, 0, 0, 32'h00028313, 0, 32'h12345000, 0, 0, 0));
    tv.push_back(mk(48,  LU|RW, 0, 0, 32'hAABBD3B7, 0, 32'hFFFFFAAB, 0, 0, 0));
    tv.push_back(mk(52,  RW, 0, 0, 32'hCDD38393, 0, 32'hAABBCCDD, 0, 0, 0));
    tv.push_back(mk(56,  RW, 0, 0, 32'h00200413, 0, 2, 0, 0, 0));
    tv.push_back(mk(60,  ST, 0, 0, 32'h00740023, 0, 2, 4'h4, 32'hDDDDDDDD, 0));
    tv.push_back(mk(64,  ST, 2, 0, 32'h00742023, 0, 2, 4'hF, 32'hAABBCCDD, 0));
    tv.push_back(mk(68,  ST, 1, 0, 32'h00741023, 0, 2, 4'hC, 32'hCCDDCCDD, 0));
    tv.push_back(mk(72,  LD|RW, 0, 0, 32'h00100483, 32'h00008000, 1, 0, 0, 0));
    tv.push_back(mk(76,  LD|RW, 4, 0, 32'h00104503, 32'h00008000, 1, 0, 0, 0));
    tv.push_back(mk(80,  LD|RW, 1, 0, 32'h00201583, 32'h80010000, 2, 0, 0, 0));
    tv.push_back(mk(84,  RW, 0, 0, 32'h00700013, 0, 7, 0, 0, 0));
    tv.push_back(mk(88,  RW, 0, 0, 32'h00048613, 0, 32'hFFFFFF80, 0, 0, 0));
    tv.push_back(mk(92,  RW, 0, 0, 32'h00050613, 0, 32'h80, 0, 0, 0));
    tv.push_back(mk(96,  RW, 0, 0, 32'h00058613, 0, 32'hFFFF8001, 0, 0, 0));
    tv.push_back(mk(100, RW, 0, 0, 32'h00000613, 0, 0, 0, 0, 0));
    tv.push_back(mk(104, RW, 0, 0, 32'h00008613, 0, 40, 0, 0, 0));
    tv.push_back(mk(108, RW, 0, 0, 32'h00010613, 0, 10, 0, 0, 0));
    tv.push_back(mk(112, RW, 0, 0, 32'h00018613, 0, 0, 0, 0, 0));
    tv.push_back(mk(116, AU|RW, 0, 0, 32'h00001697, 0, 0, 0, 0, 0));
    tv.push_back(mk(120, RW, 0, 0, 32'h00068613, 0, 32'h1074, 0, 0, 0));
    tv.push_back(mk(124, SA|RW, 5, 7, 32'h4043D713, 0, 32'hFAABBCCD, 0, 0, 0));
    tv.push_back(mk(128, AR|RW, 2, 3, 32'h0003A7B3, 0, 1, 0, 0, 0));
    tv.push_back(mk(132, RW, 0, 0, 32'h06300093, 0, 99, 0, 0, 1));
    tv.push_back(mk(0,   RW, 0, 0, 32'h00008613, 0, 0, 0, 0, 0));
    tv.push_back(mk(4,   RW, 0, 0, 32'h00028613, 0, 0, 0, 0, 0));

    drive(1, RW, 0, 0, 32'h00500093, 0);
    @(posedge clk); #1;
    chk("reset_pc1", pc, 0);
    @(posedge clk); #1;
    chk("reset_pc2", pc, 0);
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].rst, tv[i].fl, tv[i].f3, tv[i].ac, tv[i].ins, tv[i].mrd);
      #1;
      chk($sformatf("v%0d_pc", i), pc, tv[i].pc);
      chk($sformatf("v%0d_alu", i), aluOut, tv[i].alu);
      chk($sformatf("v%0d_zero", i), {31'd0, isZero}, (tv[i].alu == 0) ? 1 : 0);
      chk($sformatf("v%0d_mask", i), {28'd0, memWMask}, {28'd0, tv[i].wm});
      if (tv[i].wm != 0) chk($sformatf("v%0d_wdata", i), memWdata, tv[i].wd);
      @(posedge clk); #1;
    end

    drive(1, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    m_pc = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = 0;
    for (int n = 0; n < 600; n++) begin
      cls = $urandom_range(0, 9);
      ins = $urandom;
      f3 = 3'($urandom_range(0, 7));
      ac = 4'($urandom_range(0, 15));
      case (cls)
        0: fl = AR | RW;
        1: fl = RW;
        2: fl = SA | RW;
        3: begin fl = LD | RW; f3 = ldf[$urandom_range(0, 4)]; ac = 0; end
        4: begin fl = ST; f3 = 3'($urandom_range(0, 2)); ac = 0; end
        5: begin fl = BR | AR; ac = 1; end
        6: fl = JL | RW;
        7: fl = JR | RW;
        8: fl = LU | RW;
        default: fl = AU | RW;
      endcase
      rstep($urandom_range(0, 49) == 0, fl, f3, ac, ins, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
